// File: rtl/req_issuer_pkg.sv
// Shared constants, types and helper functions for the req_issuer requester block.
// Optional starvation monitor is enabled by defining REQ_ISSUER_STARVE_CHECK_EN.
package req_issuer_pkg;

    localparam int N_DEF        = 8;
    localparam int CNT_W_DEF    = 4;
    localparam int MAX_WAIT_DEF = 15;
    localparam int IDX_W_DEF    = $clog2(N_DEF);

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    // Legal: at most one bit, only on requesting clients, and silent while disabled.
    function automatic logic onehot_legal(
        input logic [N_DEF-1:0] gnt,
        input logic [N_DEF-1:0] req,
        input logic             en
    );
        logic w_onehot0;
        w_onehot0 = ((gnt & (gnt - 1'b1)) == '0);
        return w_onehot0 && ((gnt & ~req) == '0) && (en || (gnt == '0));
    endfunction

    function automatic logic [IDX_W_DEF-1:0] onehot2idx(input logic [N_DEF-1:0] gnt);
        logic [IDX_W_DEF-1:0] w_idx;
        w_idx = '0;
        for (int i = 0; i < N_DEF; i++) begin
            if (gnt[i]) w_idx = w_idx | IDX_W_DEF'(i);
        end
        return w_idx;
    endfunction

endpackage

// File: rtl/req_issuer_slot.sv
// One client's saturating pending-job counter with overflow detect and an optional
// wait counter (REQ_ISSUER_STARVE_CHECK_EN) that flags starvation.
module req_issuer_slot
    import req_issuer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
`ifdef REQ_ISSUER_STARVE_CHECK_EN
    , parameter int MAX_WAIT = MAX_WAIT_DEF
`endif
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_post,
    input  logic i_gnt,
    output logic o_req,
    output logic o_ovf,
    output logic o_starve
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // A post and a retirement in the same cycle cancel, so a full counter never overflows then.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_post && !i_gnt) begin
            if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
        end else if (!i_post && i_gnt) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) r_cnt <= '0;
        else            r_cnt <= w_cnt_nxt;
    end

    assign o_req = (r_cnt != '0);
    assign o_ovf = i_post && !i_gnt && (r_cnt == CNT_MAX);

`ifdef REQ_ISSUER_STARVE_CHECK_EN
    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_wait <= '0;
        end else if (i_gnt || (w_cnt_nxt == '0)) begin
            r_wait <= '0;
        end else if (o_req && (r_wait != WAIT_MAX)) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    assign o_starve = (r_wait >= WAIT_MAX);
`else
    assign o_starve = 1'b0;
`endif

endmodule

// File: rtl/req_issuer.sv
// Requester-side companion to the 8-input priority selector: per-client pending counts,
// grant legality check, registered grant index and sticky error flags.
// Optional starvation flags are built when REQ_ISSUER_STARVE_CHECK_EN is defined.
module req_issuer
    import req_issuer_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int IDX_W = $clog2(N)
`ifdef REQ_ISSUER_STARVE_CHECK_EN
    , parameter int MAX_WAIT = MAX_WAIT_DEF
`endif
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N-1:0]     post,
    input  logic             enable,
    input  logic             out_ready,
    output logic [N-1:0]     sel_req,
    output logic             sel_en,
    input  logic [N-1:0]     sel_gnt,
    input  logic             sel_req_up,
    output logic             grant_vld,
    output logic [IDX_W-1:0] grant_idx,
    output logic             overflow,
    output logic             proto_err,
    output logic [N-1:0]     starve
);

    logic [N-1:0] w_req;
    logic [N-1:0] w_ovf;
    logic [N-1:0] w_gnt_q;
    logic         w_legal;
    logic         w_up_err;

    logic             r_grant_vld;
    logic [IDX_W-1:0] r_grant_idx;
    logic             r_overflow;
    logic             r_proto_err;

    assign sel_req  = w_req;
    assign sel_en   = enable & out_ready;
    assign w_legal  = onehot_legal(sel_gnt, w_req, sel_en);
    assign w_up_err = sel_en && (sel_req_up != (|w_req));
    // An illegal grant retires nothing.
    assign w_gnt_q  = w_legal ? sel_gnt : '0;

    for (genvar gi = 0; gi < N; gi++) begin : g_slot
        req_issuer_slot #(
            .CNT_W    (CNT_W)
`ifdef REQ_ISSUER_STARVE_CHECK_EN
            , .MAX_WAIT (MAX_WAIT)
`endif
        ) u_slot (
            .i_clock   (clock),
            .i_reset_n (reset_n),
            .i_post    (post[gi]),
            .i_gnt     (w_gnt_q[gi]),
            .o_req     (w_req[gi]),
            .o_ovf     (w_ovf[gi]),
            .o_starve  (starve[gi])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_grant_vld <= 1'b0;
            r_grant_idx <= '0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_grant_vld <= (w_gnt_q != '0);
            if (w_gnt_q != '0) r_grant_idx <= onehot2idx(w_gnt_q);
            r_overflow  <= r_overflow | (|w_ovf);
            r_proto_err <= r_proto_err | !w_legal | w_up_err;
        end
    end

    assign grant_vld = r_grant_vld;
    assign grant_idx = r_grant_idx;
    assign overflow  = r_overflow;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_req_issuer.sv
// Directed plus randomized bench for req_issuer with a behavioural selector and job-count model.
module tb_req_issuer;

    localparam int N       = 8;
    localparam int CMAX    = 15;
    localparam int WAITMAX = 15;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] post = '0;
    logic       enable = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] sel_req;
    logic       sel_en;
    logic [7:0] sel_gnt;
    logic       sel_req_up;
    logic       grant_vld;
    logic [2:0] grant_idx;
    logic       overflow;
    logic       proto_err;
    logic [7:0] starve;

    // Selector stimulus overrides
    logic       ov_en = 1'b0;
    logic [7:0] ov_gnt = '0;
    logic       up_flip = 1'b0;

    // Reference model state
    int         m_cnt[N];
    int         m_wait[N];
    bit         m_ovf;
    bit         m_perr;
    logic [2:0] m_idx;
    logic [3:0] exp_q[$];

    int n_checks = 0;
    int n_err = 0;
    int n_gv = 0;

    req_issuer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .post       (post),
        .enable     (enable),
        .out_ready  (out_ready),
        .sel_req    (sel_req),
        .sel_en     (sel_en),
        .sel_gnt    (sel_gnt),
        .sel_req_up (sel_req_up),
        .grant_vld  (grant_vld),
        .grant_idx  (grant_idx),
        .overflow   (overflow),
        .proto_err  (proto_err),
        .starve     (starve)
    );

    always #5 clock = ~clock;

    // Behavioural priority selector: highest-index requester wins while enabled.
    always_comb begin
        sel_gnt = '0;
        if (ov_en) begin
            sel_gnt = ov_gnt;
        end else if (sel_en) begin
            for (int i = 0; i < N; i++) begin
                if (sel_req[i]) sel_gnt = 8'(1) << i;
            end
        end
        sel_req_up = (|sel_req) ^ up_flip;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_req();
        logic [7:0] r;
        for (int i = 0; i < N; i++) r[i] = (m_cnt[i] > 0);
        return r;
    endfunction

    function automatic logic [7:0] m_starve();
        logic [7:0] s;
        s = '0;
`ifdef REQ_ISSUER_STARVE_CHECK_EN
        for (int i = 0; i < N; i++) s[i] = (m_wait[i] >= WAITMAX);
`endif
        return s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 0;
            m_wait[i] = 0;
        end
        m_ovf  = 0;
        m_perr = 0;
        m_idx  = '0;
        exp_q.delete();
    endtask

    task automatic check_outputs(input logic [3:0] e);
        check("grant_vld", 32'(grant_vld), 32'(e[3]));
        check("grant_idx", 32'(grant_idx), 32'(e[2:0]));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("proto_err", 32'(proto_err), 32'(m_perr));
        check("starve", 32'(starve), 32'(m_starve()));
    endtask

    task automatic do_reset();
        post    = '0;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_clear();
        check("rst_sel_req", 32'(sel_req), 32'(0));
        check_outputs(4'b0000);
    endtask

    // One clock cycle: drive inputs, check combinational outputs, predict, then check registered outputs.
    task automatic step(input logic [7:0] p, input logic en, input logic rdy);
        logic [7:0] g;
        logic [3:0] e;
        bit         sen;
        bit         legal;
        bit         gb;
        bit         old_req;
        post = p;
        enable = en;
        out_ready = rdy;
        #1;
        check("sel_req", 32'(sel_req), 32'(m_req()));
        check("sel_en", 32'(sel_en), 32'(en & rdy));
        sen = en && rdy;
        g = '0;
        if (ov_en) begin
            g = ov_gnt;
        end else if (sen) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (m_cnt[i] > 0) begin
                    g[i] = 1'b1;
                    break;
                end
            end
        end
        legal = ($countones(g) <= 1) && (sen || g == '0);
        for (int i = 0; i < N; i++) if (g[i] && m_cnt[i] == 0) legal = 0;
        for (int i = 0; i < N; i++) begin
            gb = legal && g[i];
            old_req = (m_cnt[i] > 0);
            if (p[i] && !gb) begin
                if (m_cnt[i] == CMAX) m_ovf = 1;
                else m_cnt[i]++;
            end else if (!p[i] && gb) begin
                m_cnt[i]--;
            end
            if (gb || m_cnt[i] == 0) m_wait[i] = 0;
            else if (old_req && m_wait[i] < WAITMAX) m_wait[i]++;
        end
        if (legal && g != '0) begin
            for (int i = 0; i < N; i++) if (g[i]) m_idx = 3'(i);
            exp_q.push_back({1'b1, m_idx});
        end else begin
            exp_q.push_back({1'b0, m_idx});
        end
        if (!legal || (sen && up_flip)) m_perr = 1;
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check_outputs(e);
        if (grant_vld === 1'b1) n_gv++;
    endtask

    initial begin
        model_clear();
        @(posedge clock);
        #1;
        do_reset();

        // Idle: no posts, nothing happens
        for (int i = 0; i < 4; i++) step(8'h00, 1'b1, 1'b1);

        // Single post to client 7: req next cycle, grant pulse the cycle after
        step(8'h80, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b1);

        // Queue clients 6, 1 then 7 while disabled; retire order 7, 6, 1
        step(8'h42, 1'b0, 1'b1);
        step(8'h80, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b1, 1'b1);

        // Reset mid-operation discards pending jobs
        step(8'hFF, 1'b0, 1'b1);
        do_reset();
        step(8'h00, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b1);

        // Saturation: 16 posts to client 0 while disabled, then exactly 15 retirements
        for (int i = 0; i < 16; i++) step(8'h01, 1'b0, 1'b1);
        n_gv = 0;
        for (int i = 0; i < 18; i++) step(8'h00, 1'b1, 1'b1);
        check("sat_grants", 32'(n_gv), 32'(15));

        // Post and retire together on a full counter: no overflow change
        do_reset();
        for (int i = 0; i < 15; i++) step(8'h04, 1'b0, 1'b1);
        step(8'h04, 1'b1, 1'b1);
        step(8'h04, 1'b0, 1'b0);

        // Starvation: client 7 posted every cycle while client 0 waits
        do_reset();
        step(8'h81, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(8'h80, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b1, 1'b1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(8'($urandom_range(0, 255) & $urandom_range(0, 255)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 40; i++) step(8'h00, 1'b1, 1'b1);

        // Any-request mismatch while enabled
        do_reset();
        up_flip = 1'b1;
        step(8'h00, 1'b1, 1'b1);
        up_flip = 1'b0;
        step(8'h00, 1'b1, 1'b1);

        // Illegal two-hot grant: counts unchanged, no grant pulse
        do_reset();
        step(8'h03, 1'b0, 1'b1);
        ov_en  = 1'b1;
        ov_gnt = 8'h03;
        step(8'h00, 1'b1, 1'b1);
        ov_en  = 1'b0;
        step(8'h00, 1'b0, 1'b1);

        // Grant while disabled is illegal
        do_reset();
        step(8'h10, 1'b0, 1'b1);
        ov_en  = 1'b1;
        ov_gnt = 8'h10;
        step(8'h00, 1'b0, 1'b1);
        ov_en  = 1'b0;
        for (int i = 0; i < 3; i++) step(8'h00, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/req_issuer.md
Name: req_issuer

Overview:
- Requester-side companion to the 8-input priority selector (ps8); it drives the selector's req/en and consumes its gnt/req_up.
- Each of N clients posts job pulses. The block keeps a saturating pending count per client and asserts req[i] while that count is non-zero.
- Each cycle it retires the granted job and emits a registered grant index to the downstream consumer.
- It sits between client logic and the combinational priority selector.

Parameters:
- N, 8, number of clients; equals the selector width.
- CNT_W, 4, pending-counter width; max pending per client = 2^CNT_W-1.
- IDX_W, $clog2(N), width of grant_idx.
- MAX_WAIT, 15, starvation threshold in cycles; used only with REQ_ISSUER_STARVE_CHECK_EN.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- post  input  N  post[i]=1 adds one pending job to client i this cycle.
- enable  input  1  global arbitration enable.
- out_ready  input  1  downstream can accept a grant this cycle.
- sel_req  output  N  request vector to the selector.
- sel_en  output  1  enable to the selector.
- sel_gnt  input  N  one-hot grant from the selector, combinational from sel_req/sel_en.
- sel_req_up  input  1  selector's any-request output.
- grant_vld  output  1  registered pulse: one job was retired last cycle.
- grant_idx  output  IDX_W  index of the retired client; valid when grant_vld=1.
- overflow  output  1  sticky: a post was dropped because its counter was full.
- proto_err  output  1  sticky: illegal grant seen.
- starve  output  N  per-client starvation flag; tied 0 without the optional feature.

Behaviour:
- Reset (synchronous, reset_n=0 at a clock edge):
  - All counters = 0, so sel_req = 0.
  - grant_vld = 0, grant_idx = 0, overflow = 0, proto_err = 0, starve = 0.
  - Reset mid-operation discards all pending jobs; no grant_vld is produced in the cycle after reset.
- sel_req[i] = (cnt[i] != 0), combinational from registered counts.
- sel_en = enable & out_ready, combinational.
- A grant is legal when sel_gnt is one-hot or zero, sel_gnt ⊆ sel_req, and sel_gnt = 0 whenever sel_en = 0.
- Per-client counter update each cycle, with g = legal & sel_gnt[i]:
  - post=1, g=0: +1 if cnt < max. If cnt = max, the post is dropped and overflow is set.
  - post=0, g=1: cnt − 1.
  - post=1, g=1: cnt unchanged; no overflow, even when full.
- Grant output:
  - grant_vld(t+1) = legal & |sel_gnt(t).
  - grant_idx(t+1) = encoded index of sel_gnt(t).
  - Latency is exactly one cycle from grant to grant_vld.
  - grant_idx holds its last value when grant_vld = 0.
- Illegal grant:
  - proto_err is set.
  - No counter decrements and no grant_vld from that cycle.
- sel_req_up mismatch: if sel_req_up != |sel_req while sel_en = 1, proto_err is set.
- Throughput: at most one retirement per cycle; back-to-back grants are allowed.
- Priority: always the highest-index pending client, as decided by the selector; there is no fairness here.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: REQ_ISSUER_STARVE_CHECK_EN.
- Defined:
  - Per-client wait counter, saturating at MAX_WAIT.
  - It increments each cycle req[i]=1 and client i is not granted.
  - It clears to 0 on a grant to i or when cnt[i] becomes 0.
  - starve[i] = 1 while the wait counter is ≥ MAX_WAIT.
- Not defined: no wait counters; starve = 0 constantly.

Decomposition:
- Package req_issuer_pkg:
  - N_DEF, CNT_W_DEF, MAX_WAIT_DEF.
  - typedef cnt_t (logic [CNT_W-1:0]).
  - Function onehot_legal(gnt, req, en).
  - Function onehot2idx.
- One sub-module, req_issuer_slot: one client's pending counter, overflow detect and optional wait counter, generated N times.
- The top level holds the legality check, grant register and sticky flags.

Test Plan:
- Reset, enable=1, out_ready=1, post=8'b0000_0000 (idle with no posts) -> sel_req=0, grant_vld never 1, all flags 0.
- Single post=8'b1000_0000 pulse at t0 -> sel_req[7]=1 in t1, grant_vld=1 with idx=7 in t2, sel_req=0 in t2.
- post=8'b0100_0010 once, then post=8'b1000_0000 once -> retire order idx 7, 6, 1 on consecutive cycles.
- Post client 0 sixteen times with enable=0 (CNT_W=4) -> cnt saturates at 15, overflow=1. Then enable=1 -> exactly 15 grant_vld pulses with idx=0.
- Drive sel_gnt=8'b0000_0011 with cnt[1]=cnt[0]=1 -> proto_err=1, counts unchanged, no grant_vld.
- With REQ_ISSUER_STARVE_CHECK_EN defined, keep client 7 posted every cycle while client 0 holds 1 pending job -> starve[0]=1 after 15 cycles, clears the cycle after the first idle cycle in which 0 is granted.
